hazard_ctrl: RTL and testbench

- Pipeline sequencing controller: generates stall and flush controls for the IF/ID/EX pipeline registers.
- Tracks destination registers of the instructions in flight in EX, MEM and WB in an internal 3-slot shadow pipeline.
- Detects RAW hazards against the instruction currently in ID.
- Runs a flush state machine on EX branch/jump redirects; keeps stall/flush performance counters.

---
 rtl/hazard_ctrl_pkg.sv | 21 ++
 rtl/hazard_match.sv | 24 ++
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller: flush FSM state encoding and the
// layout of one shadow-pipeline slot (EX, MEM or WB).
package hazard_ctrl_pkg;

   localparam int REG_IDX_W = 5;

   typedef enum logic [0:0] {
      HAZ_STATE_IDLE  = 1'b0,
      HAZ_STATE_FLUSH = 1'b1
   } haz_state_e;

   typedef struct packed {
      logic                 valid;
      logic                 dest_en;
      logic                 is_load;
      logic [REG_IDX_W-1:0] dest_reg;
   } slot_t;

   localparam slot_t SLOT_BUBBLE = '0;

endpackage

// File: rtl/hazard_match.sv
// Compares one in-flight slot against the source operands of the ID instruction.
// Writes to register 0 never count as producers.
module hazard_match
   import hazard_ctrl_pkg::*;
(
   input  logic                 slot_valid,
   input  logic                 slot_dest_en,
   input  logic [REG_IDX_W-1:0] slot_dest_reg,
   input  logic [REG_IDX_W-1:0] rs1,
   input  logic                 rs1_used,
   input  logic [REG_IDX_W-1:0] rs2,
   input  logic                 rs2_used,
   output logic                 match
);

   logic producer;

   always_comb begin
      producer = slot_valid & slot_dest_en & (slot_dest_reg != '0);
      match    = producer & ((rs1_used & (rs1 == slot_dest_reg)) |
                             (rs2_used & (rs2 == slot_dest_reg)));
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: RAW stall detection against a 3-slot shadow
// of EX/MEM/WB, a redirect flush FSM, and stall/flush event counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int FWD_EN       = 0,
   parameter int RF_BYPASS    = 0,
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 32
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 i_id_valid,
   input  logic [REG_IDX_W-1:0] i_id_rs1,
   input  logic                 i_id_rs1_used,
   input  logic [REG_IDX_W-1:0] i_id_rs2,
   input  logic                 i_id_rs2_used,
   input  logic                 i_id_dest_en,
   input  logic [REG_IDX_W-1:0] i_id_dest_reg,
   input  logic                 i_id_is_load,
   input  logic                 i_ex_redirect,
   output logic                 o_stall,
   output logic                 o_flush,
   output logic                 o_bubble_ex,
   output logic [CNT_W-1:0]     o_stall_cnt,
   output logic [CNT_W-1:0]     o_flush_cnt
);

   // Remaining extra flush cycles after the redirect cycle itself.
   localparam logic [1:0] FLUSH_RELOAD = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;

   slot_t      slots [3];
   logic [2:0] slot_match;
   haz_state_e state;
   haz_state_e state_next;
   logic [1:0] cnt;
   logic [1:0] cnt_next;
   logic       hazard;
   logic       issue;
   slot_t      issue_slot;

   // Index 0 is EX, 1 is MEM, 2 is WB.
   for (genvar i = 0; i < 3; i++) begin : g_match
      hazard_match u_match (
         .slot_valid    (slots[i].valid),
         .slot_dest_en  (slots[i].dest_en),
         .slot_dest_reg (slots[i].dest_reg),
         .rs1           (i_id_rs1),
         .rs1_used      (i_id_rs1_used),
         .rs2           (i_id_rs2),
         .rs2_used      (i_id_rs2_used),
         .match         (slot_match[i])
      );
   end

   // With forwarding only a load still in EX cannot supply its result in time.
   always_comb begin
      hazard = 1'b0;
      if (FWD_EN != 0) begin
         hazard = slot_match[0] & slots[0].is_load;
      end else if (RF_BYPASS != 0) begin
         hazard = slot_match[0] | slot_match[1];
      end else begin
         hazard = |slot_match;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      o_flush    = 1'b0;
      case (state)
         HAZ_STATE_IDLE: begin
            o_flush = i_ex_redirect;
            if (i_ex_redirect && (FLUSH_CYCLES > 1)) begin
               state_next = HAZ_STATE_FLUSH;
               cnt_next   = FLUSH_RELOAD;
            end
         end
         HAZ_STATE_FLUSH: begin
            o_flush = 1'b1;
            if (i_ex_redirect) begin
               cnt_next = FLUSH_RELOAD;
            end else if (cnt == 2'd0) begin
               state_next = HAZ_STATE_IDLE;
            end else begin
               cnt_next = cnt - 2'd1;
            end
         end
         default: state_next = HAZ_STATE_IDLE;
      endcase

      if (clr) begin
         o_flush = 1'b0;
      end

      // A flushed instruction is on the wrong path, so flush wins over stall.
      o_stall     = i_id_valid & hazard & ~o_flush & ~clr;
      o_bubble_ex = o_stall | o_flush | clr;
      issue       = i_id_valid & ~o_stall & ~o_flush;

      issue_slot = SLOT_BUBBLE;
      if (issue) begin
         issue_slot.valid    = 1'b1;
         issue_slot.dest_en  = i_id_dest_en;
         issue_slot.is_load  = i_id_is_load;
         issue_slot.dest_reg = i_id_dest_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state <= HAZ_STATE_IDLE;
         cnt   <= 2'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // The shadow pipeline advances every cycle; stalls drain it one bubble at a time.
   always_ff @(posedge clk) begin
      if (clr) begin
         slots <= '{default: SLOT_BUBBLE};
      end else begin
         slots[2] <= slots[1];
         slots[1] <= slots[0];
         slots[0] <= issue_slot;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         o_stall_cnt <= '0;
         o_flush_cnt <= '0;
      end else begin
         if (o_stall) begin
            o_stall_cnt <= o_stall_cnt + CNT_W'(1);
         end
         if (i_ex_redirect) begin
            o_flush_cnt <= o_flush_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three configurations share one stimulus stream and are
// checked against a history-based reference model of the hazard and flush rules.
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   localparam int NCFG = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 clr;
   logic                 id_valid, rs1_used, rs2_used, dest_en, is_load, ex_redirect;
   logic [REG_IDX_W-1:0] rs1, rs2, dest_reg;

   logic [NCFG-1:0] stall_o, flush_o, bubble_o;
   logic [31:0]     stall_cnt_a, flush_cnt_a, stall_cnt_c, flush_cnt_c;
   logic [3:0]      stall_cnt_b, flush_cnt_b;
   logic [31:0]     stall_cnt_o [NCFG];
   logic [31:0]     flush_cnt_o [NCFG];

   assign stall_cnt_o[0] = stall_cnt_a;
   assign stall_cnt_o[1] = {28'd0, stall_cnt_b};
   assign stall_cnt_o[2] = stall_cnt_c;
   assign flush_cnt_o[0] = flush_cnt_a;
   assign flush_cnt_o[1] = {28'd0, flush_cnt_b};
   assign flush_cnt_o[2] = flush_cnt_c;

   hazard_ctrl #(.FWD_EN(0), .RF_BYPASS(0), .FLUSH_CYCLES(2), .CNT_W(32)) dut_a (
      .clk(clk), .clr(clr), .i_id_valid(id_valid),
      .i_id_rs1(rs1), .i_id_rs1_used(rs1_used), .i_id_rs2(rs2), .i_id_rs2_used(rs2_used),
      .i_id_dest_en(dest_en), .i_id_dest_reg(dest_reg), .i_id_is_load(is_load),
      .i_ex_redirect(ex_redirect), .o_stall(stall_o[0]), .o_flush(flush_o[0]),
      .o_bubble_ex(bubble_o[0]), .o_stall_cnt(stall_cnt_a), .o_flush_cnt(flush_cnt_a));

   hazard_ctrl #(.FWD_EN(1), .RF_BYPASS(1), .FLUSH_CYCLES(1), .CNT_W(4)) dut_b (
      .clk(clk), .clr(clr), .i_id_valid(id_valid),
      .i_id_rs1(rs1), .i_id_rs1_used(rs1_used), .i_id_rs2(rs2), .i_id_rs2_used(rs2_used),
      .i_id_dest_en(dest_en), .i_id_dest_reg(dest_reg), .i_id_is_load(is_load),
      .i_ex_redirect(ex_redirect), .o_stall(stall_o[1]), .o_flush(flush_o[1]),
      .o_bubble_ex(bubble_o[1]), .o_stall_cnt(stall_cnt_b), .o_flush_cnt(flush_cnt_b));

   hazard_ctrl #(.FWD_EN(0), .RF_BYPASS(1), .FLUSH_CYCLES(3), .CNT_W(32)) dut_c (
      .clk(clk), .clr(clr), .i_id_valid(id_valid),
      .i_id_rs1(rs1), .i_id_rs1_used(rs1_used), .i_id_rs2(rs2), .i_id_rs2_used(rs2_used),
      .i_id_dest_en(dest_en), .i_id_dest_reg(dest_reg), .i_id_is_load(is_load),
      .i_ex_redirect(ex_redirect), .o_stall(stall_o[2]), .o_flush(flush_o[2]),
      .o_bubble_ex(bubble_o[2]), .o_stall_cnt(stall_cnt_c), .o_flush_cnt(flush_cnt_c));

   int errors = 0;
   int checks = 0;

   // Reference model: per configuration, the last three issued instructions (age 0 = EX),
   // the number of owed flush cycles, and the event counts.
   bit                 h_valid [NCFG][3];
   bit                 h_den   [NCFG][3];
   bit                 h_load  [NCFG][3];
   bit [REG_IDX_W-1:0] h_dest  [NCFG][3];
   int                 m_rem       [NCFG];
   longint unsigned    m_stall_cnt [NCFG];
   longint unsigned    m_flush_cnt [NCFG];
   bit                 exp_stall [NCFG];
   bit                 exp_flush [NCFG];
   bit                 exp_bubble [NCFG];

   function automatic bit cfg_fwd(int k);
      return k == 1;
   endfunction

   function automatic bit cfg_byp(int k);
      return k != 0;
   endfunction

   function automatic int cfg_fc(int k);
      case (k)
         0:       return 2;
         1:       return 1;
         default: return 3;
      endcase
   endfunction

   function automatic longint unsigned cfg_mask(int k);
      return (k == 1) ? 64'd15 : 64'hFFFF_FFFF;
   endfunction

   task automatic model_eval();
      bit haz, prod, rd, counts;
      for (int k = 0; k < NCFG; k++) begin
         haz = 1'b0;
         for (int a = 0; a < 3; a++) begin
            prod   = h_valid[k][a] && h_den[k][a] && (h_dest[k][a] != 0);
            rd     = (rs1_used && rs1 == h_dest[k][a]) || (rs2_used && rs2 == h_dest[k][a]);
            counts = cfg_fwd(k) ? (a == 0 && h_load[k][a]) : (a < (cfg_byp(k) ? 2 : 3));
            if (prod && rd && counts) haz = 1'b1;
         end
         exp_flush[k]  = !clr && (ex_redirect || m_rem[k] > 0);
         exp_stall[k]  = !clr && id_valid && haz && !exp_flush[k];
         exp_bubble[k] = clr || exp_stall[k] || exp_flush[k];
      end
   endtask

   task automatic model_advance();
      bit issue;
      for (int k = 0; k < NCFG; k++) begin
         if (clr) begin
            for (int a = 0; a < 3; a++) h_valid[k][a] = 1'b0;
            m_rem[k]       = 0;
            m_stall_cnt[k] = 0;
            m_flush_cnt[k] = 0;
         end else begin
            issue = id_valid && !exp_stall[k] && !exp_flush[k];
            for (int a = 2; a > 0; a--) begin
               h_valid[k][a] = h_valid[k][a-1];
               h_den[k][a]   = h_den[k][a-1];
               h_load[k][a]  = h_load[k][a-1];
               h_dest[k][a]  = h_dest[k][a-1];
            end
            h_valid[k][0]  = issue;
            h_den[k][0]    = dest_en;
            h_load[k][0]   = is_load;
            h_dest[k][0]   = dest_reg;
            m_stall_cnt[k] = (m_stall_cnt[k] + 64'(exp_stall[k])) & cfg_mask(k);
            m_flush_cnt[k] = (m_flush_cnt[k] + 64'(ex_redirect)) & cfg_mask(k);
            m_rem[k]       = ex_redirect ? cfg_fc(k) - 1 : (m_rem[k] > 0 ? m_rem[k] - 1 : 0);
         end
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [REG_IDX_W-1:0] r1, input logic u1,
                                input logic [REG_IDX_W-1:0] r2, input logic u2, input logic den,
                                input logic [REG_IDX_W-1:0] dreg, input logic ld, input logic redir);
      id_valid = v;   rs1 = r1;       rs1_used = u1;  rs2 = r2;   rs2_used = u2;
      dest_en = den;  dest_reg = dreg; is_load = ld;  ex_redirect = redir;
   endtask

   task automatic settle();
      #1;
      model_eval();
   endtask

   task automatic tick();
      model_advance();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      clr = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      tick();
      clr = 1'b0;
   endtask

   task automatic test_reset();
      clr = 1'b1;
      applyStimulus(1, 5, 1, 5, 1, 1, 5, 1, 1);
      settle();
      for (int k = 0; k < NCFG; k++) begin
         checks++;
         if (stall_o[k] !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall cfg%0d: got %0b expected 0", k, stall_o[k]); end
         checks++;
         if (flush_o[k] !== 1'b0) begin errors++; $display("[TB] FAIL reset_flush cfg%0d: got %0b expected 0", k, flush_o[k]); end
         checks++;
         if (bubble_o[k] !== 1'b1) begin errors++; $display("[TB] FAIL reset_bubble cfg%0d: got %0b expected 1", k, bubble_o[k]); end
      end
      tick();
      clr = 1'b0;
      applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0);
      settle();
      for (int k = 0; k < NCFG; k++) begin
         checks++;
         if ({stall_o[k], flush_o[k], bubble_o[k]} !== 3'b000) begin
            errors++; $display("[TB] FAIL post_reset_ctrl cfg%0d: got %b expected 000", k, {stall_o[k], flush_o[k], bubble_o[k]});
         end
         checks++;
         if (stall_cnt_o[k] !== 0 || flush_cnt_o[k] !== 0) begin
            errors++; $display("[TB] FAIL post_reset_cnt cfg%0d: got %0d/%0d expected 0/0", k, stall_cnt_o[k], flush_cnt_o[k]);
         end
      end
      tick();
   endtask

   task automatic test_raw_stall();
      int stall_len [NCFG] = '{3, 0, 2};
      do_reset();
      applyStimulus(1, 0, 0, 0, 0, 1, 5, 0, 0);
      settle();
      tick();
      applyStimulus(1, 5, 1, 0, 0, 1, 6, 0, 0);
      for (int c = 0; c < 4; c++) begin
         settle();
         for (int k = 0; k < NCFG; k++) begin
            checks++;
            if (stall_o[k] !== (c < stall_len[k])) begin
               errors++; $display("[TB] FAIL raw_stall cfg%0d cyc%0d: got %0b expected %0b", k, c, stall_o[k], c < stall_len[k]);
            end
            checks++;
            if (bubble_o[k] !== (c < stall_len[k])) begin
               errors++; $display("[TB] FAIL raw_bubble cfg%0d cyc%0d: got %0b expected %0b", k, c, bubble_o[k], c < stall_len[k]);
            end
         end
         if (c == 3) begin
            for (int k = 0; k < NCFG; k++) begin
               checks++;
               if (stall_cnt_o[k] !== 32'(stall_len[k])) begin
                  errors++; $display("[TB] FAIL raw_stall_cnt cfg%0d: got %0d expected %0d", k, stall_cnt_o[k], stall_len[k]);
               end
            end
         end
         tick();
      end
      // The consumer issued on the last cycle, so a reader of x6 must stall in cfg0.
      applyStimulus(1, 6, 1, 0, 0, 0, 0, 0, 0);
      settle();
      checks++;
      if (stall_o[0] !== 1'b1) begin errors++; $display("[TB] FAIL raw_issued cfg0: got %0b expected 1", stall_o[0]); end
      tick();
   endtask

   task automatic test_load_use();
      int stall_len [NCFG] = '{3, 1, 2};
      do_reset();
      applyStimulus(1, 0, 0, 0, 0, 1, 7, 1, 0);
      settle();
      tick();
      applyStimulus(1, 7, 0, 7, 1, 0, 0, 0, 0);
      for (int c = 0; c < 4; c++) begin
         settle();
         for (int k = 0; k < NCFG; k++) begin
            checks++;
            if (stall_o[k] !== (c < stall_len[k])) begin
               errors++; $display("[TB] FAIL load_use cfg%0d cyc%0d: got %0b expected %0b", k, c, stall_o[k], c < stall_len[k]);
            end
         end
         tick();
      end
      do_reset();
      applyStimulus(1, 0, 0, 0, 0, 1, 7, 0, 0);
      settle();
      tick();
      applyStimulus(1, 7, 0, 7, 1, 0, 0, 0, 0);
      for (int c = 0; c < 2; c++) begin
         settle();
         checks++;
         if (stall_o[1] !== 1'b0) begin errors++; $display("[TB] FAIL fwd_alu cfg1 cyc%0d: got %0b expected 0", c, stall_o[1]); end
         tick();
      end
   endtask

   task automatic test_x0_and_unused();
      for (int s = 0; s < 2; s++) begin
         do_reset();
         if (s == 0) applyStimulus(1, 0, 0, 0, 0, 1, 0, 1, 0);
         else        applyStimulus(1, 0, 0, 0, 0, 1, 9, 1, 0);
         settle();
         tick();
         if (s == 0) applyStimulus(1, 0, 1, 0, 1, 0, 0, 0, 0);
         else        applyStimulus(1, 9, 0, 3, 1, 0, 0, 0, 0);
         for (int c = 0; c < 3; c++) begin
            settle();
            for (int k = 0; k < NCFG; k++) begin
               checks++;
               if (stall_o[k] !== 1'b0) begin
                  errors++; $display("[TB] FAIL no_dep_s%0d cfg%0d cyc%0d: got %0b expected 0", s, k, c, stall_o[k]);
               end
            end
            tick();
         end
      end
   endtask

   task automatic test_flush();
      int len1 [NCFG] = '{2, 1, 3};
      int len2 [NCFG] = '{3, 2, 4};
      int len;
      for (int s = 0; s < 2; s++) begin
         do_reset();
         for (int c = 0; c < 5; c++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, (s == 0) ? (c == 0) : (c <= 1));
            settle();
            for (int k = 0; k < NCFG; k++) begin
               len = (s == 0) ? len1[k] : len2[k];
               checks++;
               if (flush_o[k] !== (c < len) || bubble_o[k] !== (c < len)) begin
                  errors++; $display("[TB] FAIL flush_s%0d cfg%0d cyc%0d: got flush=%0b bubble=%0b expected %0b", s, k, c, flush_o[k], bubble_o[k], c < len);
               end
            end
            tick();
         end
         settle();
         for (int k = 0; k < NCFG; k++) begin
            checks++;
            if (flush_cnt_o[k] !== 32'(s + 1)) begin
               errors++; $display("[TB] FAIL flush_cnt_s%0d cfg%0d: got %0d expected %0d", s, k, flush_cnt_o[k], s + 1);
            end
         end
      end
   endtask

   task automatic test_flush_over_stall();
      do_reset();
      applyStimulus(1, 0, 0, 0, 0, 1, 5, 0, 0);
      settle();
      tick();
      applyStimulus(1, 5, 1, 0, 0, 1, 8, 0, 1);
      settle();
      for (int k = 0; k < NCFG; k++) begin
         checks++;
         if ({stall_o[k], flush_o[k], bubble_o[k]} !== 3'b011) begin
            errors++; $display("[TB] FAIL flush_over_stall cfg%0d: got %b expected 011", k, {stall_o[k], flush_o[k], bubble_o[k]});
         end
      end
      tick();
      // A reader of x8 must never stall: the flushed instruction was not issued.
      applyStimulus(1, 8, 1, 0, 0, 0, 0, 0, 0);
      for (int c = 1; c < 4; c++) begin
         settle();
         for (int k = 0; k < NCFG; k++) begin
            checks++;
            if (stall_o[k] !== 1'b0) begin
               errors++; $display("[TB] FAIL flushed_not_issued cfg%0d cyc%0d: got %0b expected 0", k, c, stall_o[k]);
            end
         end
         tick();
      end
   endtask

   task automatic test_clr_mid();
      do_reset();
      applyStimulus(1, 0, 0, 0, 0, 1, 5, 0, 0);
      settle();
      tick();
      applyStimulus(1, 5, 1, 0, 0, 1, 6, 0, 0);
      settle();
      checks++;
      if (stall_o[0] !== 1'b1) begin errors++; $display("[TB] FAIL clr_pre_stall cfg0: got %0b expected 1", stall_o[0]); end
      tick();
      clr = 1'b1;
      settle();
      for (int k = 0; k < NCFG; k++) begin
         checks++;
         if ({stall_o[k], flush_o[k], bubble_o[k]} !== 3'b001) begin
            errors++; $display("[TB] FAIL clr_mid_stall cfg%0d: got %b expected 001", k, {stall_o[k], flush_o[k], bubble_o[k]});
         end
      end
      tick();
      clr = 1'b0;
      applyStimulus(1, 3, 1, 0, 0, 1, 4, 0, 0);
      settle();
      for (int k = 0; k < NCFG; k++) begin
         checks++;
         if ({stall_o[k], flush_o[k], bubble_o[k]} !== 3'b000 || stall_cnt_o[k] !== 0 || flush_cnt_o[k] !== 0) begin
            errors++; $display("[TB] FAIL clr_after cfg%0d: got ctl=%b cnt=%0d/%0d expected 000 0/0", k, {stall_o[k], flush_o[k], bubble_o[k]}, stall_cnt_o[k], flush_cnt_o[k]);
         end
      end
      tick();
      applyStimulus(1, 4, 1, 0, 0, 0, 0, 0, 0);
      settle();
      checks++;
      if (stall_o[0] !== 1'b1) begin errors++; $display("[TB] FAIL clr_fresh_issue cfg0: got %0b expected 1", stall_o[0]); end
      tick();
      do_reset();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      settle();
      tick();
      clr = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      tick();
      clr = 1'b0;
      settle();
      for (int k = 0; k < NCFG; k++) begin
         checks++;
         if (flush_o[k] !== 1'b0) begin errors++; $display("[TB] FAIL clr_mid_flush cfg%0d: got %0b expected 0", k, flush_o[k]); end
      end
      tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 600; n++) begin
         clr = ($urandom_range(0, 199) == 0);
         applyStimulus($urandom_range(0, 9) < 8, REG_IDX_W'($urandom_range(0, 3)), 1'($urandom),
                       REG_IDX_W'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                       REG_IDX_W'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 7) == 0);
         settle();
         for (int k = 0; k < NCFG; k++) begin
            checks++;
            if ({stall_o[k], flush_o[k], bubble_o[k]} !== {exp_stall[k], exp_flush[k], exp_bubble[k]}) begin
               errors++; $display("[TB] FAIL rand_ctl cfg%0d n%0d: got %b expected %b", k, n, {stall_o[k], flush_o[k], bubble_o[k]}, {exp_stall[k], exp_flush[k], exp_bubble[k]});
            end
            checks++;
            if (stall_cnt_o[k] !== 32'(m_stall_cnt[k]) || flush_cnt_o[k] !== 32'(m_flush_cnt[k])) begin
               errors++; $display("[TB] FAIL rand_cnt cfg%0d n%0d: got %0d/%0d expected %0d/%0d", k, n, stall_cnt_o[k], flush_cnt_o[k], m_stall_cnt[k], m_flush_cnt[k]);
            end
         end
         tick();
      end
      clr = 1'b0;
   endtask

   initial begin
      clr = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      test_reset();
      test_raw_stall();
      test_load_use();
      test_x0_and_unused();
      test_flush();
      test_flush_over_stall();
      test_clr_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
